bnn_in_stage: RTL
=================

# bnn_in_stage

Input staging block between the pad ring and the BNN core. It accepts 16-bit activation/weight words from the input pads under a valid/ready handshake and buffers them in a small synchronous FIFO. It tags each word with a frame-stable mode bit and an end-of-frame marker, then presents them to the core under a second valid/ready handshake. This decouples host timing from core back-pressure and guarantees that `mode` cannot change inside a frame.

## Interface
Parameters:
- `DW`, 16: data word width.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `FRAME_LEN`, 64: words per frame; at least 1.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous, active-high.
- `mode_i`  in  1  mode from the pad; sampled only on the first word of each frame.
- `s_data`  in  DW  input word from the pads.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block can accept a word.
- `m_data`  out  DW  word to the core.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  core accepts `m_data`.
- `m_mode`  out  1  mode bit travelling with `m_data`.
- `m_last`  out  1  `m_data` is the last word of its frame.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame has been popped.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- Push occurs when `s_valid && s_ready`. Pop occurs when `m_valid && m_ready`.
- `s_ready = (level != DEPTH)`. `m_valid = (level != 0)`. Both are combinational from registered state.
- Each entry stores {mode, last, data}.
- Input word counter `in_cnt` runs 0..FRAME_LEN-1 and advances on every push. It wraps to 0 after the push that completes a frame.
- Mode tagging:
  - On a push with `in_cnt == 0`, the entry mode is `mode_i` and `frame_mode` is loaded with `mode_i`.
  - On any other push, the entry mode is `frame_mode`.
  - Changes on `mode_i` mid-frame are ignored.
- `last` is set on an entry when `in_cnt == FRAME_LEN-1` at push time. With `FRAME_LEN == 1`, every entry is last.
- `frame_done` is registered. It is high in the cycle after a pop whose entry had `last` set.
- Simultaneous push and pop:
  - When not full and not empty, both happen and `level` is unchanged.
  - When full, no push occurs because `s_ready` is low, even if a pop happens that cycle. There is no same-cycle bypass.
  - When empty, no pop occurs. There is no fall-through.
- Pointer arithmetic:
  - Read and write pointers are `$clog2(DEPTH)` bits wide and wrap naturally at DEPTH.
  - `level` is a separate counter: +1 on push-only, -1 on pop-only.
- Reset, including mid-frame:
  - Pointers, `level`, `in_cnt`, `frame_mode` and `frame_done` clear to 0, and all buffered words are discarded.
  - Output values during reset: `s_ready=1`, `m_valid=0`, `m_last=0`, `m_mode=0`, `frame_done=0`, `level=0`.
  - `m_data` is don't-care while `m_valid=0`.

## Timing
- Latency: a word pushed at edge N is visible with `m_valid=1` after edge N, when the FIFO was empty. That is one cycle of latency.
- Sustained throughput is one word per cycle whenever `level` is between 1 and DEPTH-1.
- `m_data`, `m_mode` and `m_last` are stable while `m_valid && !m_ready`.
- `s_ready` falls in the cycle after the push that fills the FIFO.
- The upstream source must hold `s_data` while `s_valid && !s_ready`.

## Configuration
- Macro: `BNN_IN_STAGE_PARITY_EN`.
- When defined:
  - Adds input port `s_par` (1 bit, even parity over `s_data`) and output port `par_err` (1 bit, sticky).
  - `par_err` is set in the cycle after any push where `^{s_data, s_par} == 1`.
  - `par_err` is cleared only by `rst`.
  - The erroneous word is still buffered and forwarded unchanged.
- When undefined: neither port exists and there is no parity logic.

## Structure
- Shared package `bnn_pkg` holds:
  - `BNN_DW` (16) and `BNN_FRAME_LEN` (64) constants.
  - `bnn_in_entry_t` packed struct {mode, last, data[BNN_DW-1:0]}.
- Natural sub-module: `bnn_sync_fifo`, a generic DEPTH × width register FIFO with push/pop/full/empty/level ports.
- `bnn_in_stage` wraps `bnn_sync_fifo` with the frame counter, mode latch, `frame_done` and optional parity logic.

## Test plan
- Reset then single word: push 0xA5A5 with `mode_i=1` and `m_ready=1` -> one cycle later `m_valid=1`, `m_data=0xA5A5`, `m_mode=1`, `m_last=0`; `level` goes 0→1→0.
- Fill and stall: with `m_ready=0` and DEPTH=4, push 0x0001..0x0005 -> `s_ready` drops after 4 pushes and `level=4`. Then release `m_ready` -> data pops in order 1,2,3,4, then 5 is accepted.
- Frame tagging: with FRAME_LEN=4, push 8 words with `mode_i=1` on word 0, toggling mid-frame, and `mode_i=0` on word 4 -> words 0–3 have `m_mode=1` and words 4–7 have `m_mode=0`. `m_last` is set on words 3 and 7. `frame_done` pulses one cycle after each of those pops.
- Simultaneous push/pop at `level=2` with `s_valid=m_ready=1` for 10 cycles -> `level` stays 2 and output order is preserved.
- Reset mid-frame: assert `rst` with `level=3` and `in_cnt=2` -> after release, `level=0` and `m_valid=0`. The next pushed word takes `mode_i` as the frame mode and starts a new frame.
- With `BNN_IN_STAGE_PARITY_EN`: push 0x0003 with `s_par=1` -> `par_err` rises one cycle later, the word is still output, and `par_err` stays high until `rst`.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and entry type for the BNN input path.
//   BNN_DW         default data word width
//   BNN_FRAME_LEN  default words per frame
//   bnn_in_entry_t one buffered word with its frame tags {mode, last, data}
package bnn_pkg;

    localparam int BNN_DW        = 16;
    localparam int BNN_FRAME_LEN = 64;

    typedef struct packed {
        logic              mode;
        logic              last;
        logic [BNN_DW-1:0] data;
    } bnn_in_entry_t;

endpackage

// File: rtl/bnn_sync_fifo.sv
// bnn_sync_fifo: generic DEPTH x W register FIFO, no bypass, no fall-through.
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  write request and word (caller must not push when full)
//   pop, rdata   read request and head word (rdata valid while !empty)
//   full, empty  occupancy flags
//   level        occupancy 0..DEPTH
module bnn_sync_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign rdata = mem[rptr];

    // Storage is not reset: stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= push && !pop ? level + 1'b1 :
                     pop && !push ? level - 1'b1 : level;
        end
    end

endmodule

// File: rtl/bnn_in_stage.sv
// bnn_in_stage: pad-to-core input staging FIFO with frame-stable mode and end-of-frame tags.
//   clk, rst                  clock, asynchronous active-high reset
//   mode_i                    pad mode, sampled on the first word of each frame
//   s_data, s_valid, s_ready  upstream handshake from the pads
//   m_data, m_valid, m_ready  downstream handshake to the core
//   m_mode, m_last            tags travelling with m_data
//   frame_done                one-cycle pulse after the last word of a frame is popped
//   level                     FIFO occupancy 0..DEPTH
//   s_par, par_err            even parity in / sticky error out, only with BNN_IN_STAGE_PARITY_EN
module bnn_in_stage
    import bnn_pkg::*;
#(
    parameter int DW        = BNN_DW,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = BNN_FRAME_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode_i,
    input  logic [DW-1:0]          s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DW-1:0]          m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_mode,
    output logic                   m_last,
    output logic                   frame_done,
`ifdef BNN_IN_STAGE_PARITY_EN
    output logic [$clog2(DEPTH):0] level,
    input  logic                   s_par,
    output logic                   par_err
`else
    output logic [$clog2(DEPTH):0] level
`endif
);

    // A one-word frame still needs a 1-bit counter that simply stays at zero.
    localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    logic          push, pop, full, empty;
    logic          frame_mode, entry_mode, entry_last;
    logic [CW-1:0] in_cnt;
    logic [DW+1:0] wdata, rdata;

    assign s_ready    = !full;
    assign m_valid    = !empty;
    assign push       = s_valid && s_ready;
    assign pop        = m_valid && m_ready;
    assign entry_mode = in_cnt == '0 ? mode_i : frame_mode;
    assign entry_last = in_cnt == LAST_CNT;
    assign wdata      = {entry_mode, entry_last, s_data};

    bnn_sync_fifo #(.W(DW + 2), .DEPTH(DEPTH)) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Tags are forced low while empty so reset and idle never show stale flags.
    assign m_data = rdata[DW-1:0];
    assign m_last = m_valid && rdata[DW];
    assign m_mode = m_valid && rdata[DW+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt     <= '0;
            frame_mode <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (push) begin
                in_cnt <= entry_last ? '0 : in_cnt + 1'b1;
                if (in_cnt == '0) frame_mode <= mode_i;
            end
            frame_done <= pop && rdata[DW];
        end
    end

`ifdef BNN_IN_STAGE_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else if (push && ^{s_data, s_par}) par_err <= 1'b1;
    end
`endif

endmodule
